wm_cycle_responder: RTL and testbench
=====================================

// Module: wm_cycle_responder
// PURPOSE
//   Appliance-side responder to the washing-machine controller. Accepts one operation request
//   (water intake, soak, wash, rinse or spin) at a time and drives the fill/drain valves, the drum
//   motor and the lid lock. It times each phase and returns a one-cycle *_done pulse, so the
//   controller advances its state on completion handshakes, not on free-running timers.
// PARAMETERS
//   CNT_W        16   width of the phase down-counter
//   FILL_CYCLES  16   cycles of fill_valve to reach water_full
//   SOAK_CYCLES  64   soak duration, motor off
//   WASH_CYCLES  128  wash duration, motor_en=1, motor_fast=0
//   RINSE_CYCLES 64   rinse agitation, followed by drain
//   DRAIN_CYCLES 16   drain duration at end of rinse
//   SPIN_CYCLES  96   spin duration, motor_fast=1, drain_valve=1
// PORTS
//   clock        in   1  system clock, rising edge
//   reset_n      in   1  asynchronous, active-low reset
//   lid          in   1  1 = lid open
//   water_intake in   1  fill request (level, held until fill_done)
//   soak_req     in   1  soak request (level)
//   wash_req     in   1  wash request (level)
//   rinse_req    in   1  rinse request (level)
//   spin_req     in   1  spin request (level)
//   fill_done, soak_done, wash_done, rinse_done, spin_done  out 1 each  completion pulses
//   water_full   out  1  drum holds water
//   fill_valve   out  1  inlet valve on
//   drain_valve  out  1  drain valve on
//   motor_en     out  1  drum motor on
//   motor_fast   out  1  spin speed (valid with motor_en)
//   lid_lock     out  1  lid locked
//   fault        out  1  protocol fault (more than one request)
// BEHAVIOUR
//   - Reset: state IDLE, counter 0, every output 0 including water_full.
//   - FSM: IDLE, FILL, SOAK, WASH, RINSE, DRAIN, SPIN, DONE, FAULT.
//   - IDLE: exactly one request high at a posedge -> enter that phase and load the counter with
//     N-1. Zero requests -> stay in IDLE. Two or more -> FAULT.
//   - Actuators are registered and turn on in the first phase cycle.
//   - While running, the counter decrements once per cycle. At 0 the FSM moves to DONE
//     (RINSE moves to DRAIN first).
//   - Timing, lid closed throughout: the *_done pulse is high in cycle N+1 after the request is
//     first sampled. RINSE done comes at RINSE_CYCLES+DRAIN_CYCLES+1.
//   - DONE: *_done is high for one cycle only. The FSM then waits in DONE until every request is
//     low, then returns to IDLE. A request still held causes no retrigger.
//   - FILL: fill_valve=1; at the end water_full<=1. If water_full is already 1, fill_done pulses
//     the next cycle without filling.
//   - SOAK, WASH, RINSE: need water_full=1. If it is 0, wait in the phase with the counter frozen
//     and actuators off.
//   - DRAIN and SPIN: drain_valve=1. water_full<=0 on the first cycle of DRAIN/SPIN.
//   - lid_lock=1 in FILL..SPIN and in DONE. It is 0 in IDLE and FAULT.
//   - Lid open during a phase:
//     * counter frozen; motor_en, motor_fast and fill_valve forced to 0;
//     * drain_valve and water_full keep their values;
//     * resume on the cycle after the lid closes.
//   - Request dropped mid-phase (cancel):
//     * go to IDLE at the next posedge; all actuators 0 one cycle later;
//     * no *_done pulse; water_full keeps its value.
//   - FAULT: fault=1 and all actuators 0. Leave to IDLE when all requests are low.
//     A request change in a phase (other than dropping it) is ignored.
//   - Reset mid-phase: immediate return to reset values; water_full is cleared.
//   - The counter never wraps. A parameter of 0 is treated as 1.
// CONFIGURATION
//   WM_RESP_STATUS_EN defined:
//     adds output phase_remaining [CNT_W-1:0] (current counter value, 0 in IDLE/DONE/FAULT);
//     adds output phase_code [2:0] (0 IDLE, 1 FILL, 2 SOAK, 3 WASH, 4 RINSE, 5 DRAIN, 6 SPIN,
//     7 DONE/FAULT).
//   Undefined: both ports absent; all other behaviour identical.
// TESTING  (FILL=4, WASH=8, RINSE=4, DRAIN=2, SPIN=6)
//   reset_n low mid-WASH -> all outputs 0 at once, water_full=0, IDLE after release
//   water_intake high from cycle 0 -> fill_valve cycles 1-4, water_full=1 at cycle 5,
//     fill_done at cycle 5 only
//   wash_req with water_full=1, lid open cycles 3-5 -> motor_en low in 3-5, wash_done at
//     cycle 12; held req gives no second pulse
//   rinse_req -> motor_en cycles 1-4, drain_valve cycles 5-6, water_full=0, rinse_done at cycle 7
//   wash_req and spin_req high together -> fault=1 next cycle, actuators 0, IDLE after both low
//   spin_req dropped at cycle 3 -> motor off by cycle 5, spin_done never pulses

Source files
------------

// File: rtl/wm_cycle_responder_if.sv
// Request/completion and actuator bundle between the wash controller (master) and the
// appliance-side responder (slave).
interface wm_cycle_responder_if;
  // Handshake: each *_req / water_intake is a level held by the master until the matching
  // *_done pulse (one cycle). Dropping it earlier cancels the phase without a done pulse.
  // A new request is accepted only after all requests have been low once.
  logic lid;
  logic water_intake;
  logic soak_req;
  logic wash_req;
  logic rinse_req;
  logic spin_req;
  logic fill_done;
  logic soak_done;
  logic wash_done;
  logic rinse_done;
  logic spin_done;
  logic water_full;
  logic fill_valve;
  logic drain_valve;
  logic motor_en;
  logic motor_fast;
  logic lid_lock;
  logic fault;

  modport master (
    output lid, water_intake, soak_req, wash_req, rinse_req, spin_req,
    input  fill_done, soak_done, wash_done, rinse_done, spin_done,
    input  water_full, fill_valve, drain_valve, motor_en, motor_fast, lid_lock, fault
  );

  modport slave (
    input  lid, water_intake, soak_req, wash_req, rinse_req, spin_req,
    output fill_done, soak_done, wash_done, rinse_done, spin_done,
    output water_full, fill_valve, drain_valve, motor_en, motor_fast, lid_lock, fault
  );
endinterface

// File: rtl/wm_cycle_responder.sv
// Washing-machine phase responder: times fill/soak/wash/rinse(+drain)/spin and pulses *_done.
// Optional status ports (phase_remaining, phase_code) are built when WM_RESP_STATUS_EN is defined.
module wm_cycle_responder #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned FILL_CYCLES  = 16,
  parameter int unsigned SOAK_CYCLES  = 64,
  parameter int unsigned WASH_CYCLES  = 128,
  parameter int unsigned RINSE_CYCLES = 64,
  parameter int unsigned DRAIN_CYCLES = 16,
  parameter int unsigned SPIN_CYCLES  = 96
) (
  input  logic                 clock,
  input  logic                 reset_n,
  wm_cycle_responder_if.slave  bus,
  output logic [3:0]           state_dbg
`ifdef WM_RESP_STATUS_EN
  ,
  output logic [CNT_W-1:0]     phase_remaining,
  output logic [2:0]           phase_code
`endif
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    FILL  = 4'd1,
    SOAK  = 4'd2,
    WASH  = 4'd3,
    RINSE = 4'd4,
    DRAIN = 4'd5,
    SPIN  = 4'd6,
    DONE  = 4'd7,
    FAULT = 4'd8
  } state_t;

  // A zero-length phase behaves as a one-cycle phase.
  localparam int unsigned FILL_N  = (FILL_CYCLES  == 0) ? 1 : FILL_CYCLES;
  localparam int unsigned SOAK_N  = (SOAK_CYCLES  == 0) ? 1 : SOAK_CYCLES;
  localparam int unsigned WASH_N  = (WASH_CYCLES  == 0) ? 1 : WASH_CYCLES;
  localparam int unsigned RINSE_N = (RINSE_CYCLES == 0) ? 1 : RINSE_CYCLES;
  localparam int unsigned DRAIN_N = (DRAIN_CYCLES == 0) ? 1 : DRAIN_CYCLES;
  localparam int unsigned SPIN_N  = (SPIN_CYCLES  == 0) ? 1 : SPIN_CYCLES;

  localparam logic [CNT_W-1:0] FILL_LOAD  = CNT_W'(FILL_N  - 1);
  localparam logic [CNT_W-1:0] SOAK_LOAD  = CNT_W'(SOAK_N  - 1);
  localparam logic [CNT_W-1:0] WASH_LOAD  = CNT_W'(WASH_N  - 1);
  localparam logic [CNT_W-1:0] RINSE_LOAD = CNT_W'(RINSE_N - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_N - 1);
  localparam logic [CNT_W-1:0] SPIN_LOAD  = CNT_W'(SPIN_N  - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             fill_q, drain_q, motor_q, fast_q, lock_q, fault_q, water_q;
  logic [4:0]       done_q;

  // Bit order everywhere: 0 fill, 1 soak, 2 wash, 3 rinse, 4 spin.
  logic [4:0] req;
  logic       req_none, req_one, active_req, needs_water;
  logic [4:0] phase_bit;

  assign req      = {bus.spin_req, bus.rinse_req, bus.wash_req, bus.soak_req, bus.water_intake};
  assign req_none = (req == 5'd0);
  assign req_one  = !req_none && ((req & (req - 5'd1)) == 5'd0);
  assign needs_water = (state == SOAK) || (state == WASH) || (state == RINSE);

  always_comb begin
    active_req = 1'b0;
    phase_bit  = 5'd0;
    case (state)
      FILL:        begin active_req = req[0]; phase_bit = 5'b00001; end
      SOAK:        begin active_req = req[1]; phase_bit = 5'b00010; end
      WASH:        begin active_req = req[2]; phase_bit = 5'b00100; end
      RINSE, DRAIN: begin active_req = req[3]; phase_bit = 5'b01000; end
      SPIN:        begin active_req = req[4]; phase_bit = 5'b10000; end
      default:     begin active_req = 1'b0;   phase_bit = 5'd0;     end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      fill_q  <= 1'b0;
      drain_q <= 1'b0;
      motor_q <= 1'b0;
      fast_q  <= 1'b0;
      lock_q  <= 1'b0;
      fault_q <= 1'b0;
      water_q <= 1'b0;
      done_q  <= 5'd0;
    end else begin
      done_q <= 5'd0;
      case (state)
        IDLE: begin
          if (req_one) begin
            lock_q <= 1'b1;
            if (req[0]) begin
              if (water_q) begin
                state     <= DONE;
                done_q[0] <= 1'b1;
              end else begin
                state  <= FILL;
                cnt    <= FILL_LOAD;
                fill_q <= 1'b1;
              end
            end else if (req[1]) begin
              state <= SOAK;
              cnt   <= SOAK_LOAD;
            end else if (req[2]) begin
              state   <= WASH;
              cnt     <= WASH_LOAD;
              motor_q <= water_q;
            end else if (req[3]) begin
              state   <= RINSE;
              cnt     <= RINSE_LOAD;
              motor_q <= water_q;
            end else begin
              state   <= SPIN;
              cnt     <= SPIN_LOAD;
              motor_q <= 1'b1;
              fast_q  <= 1'b1;
              drain_q <= 1'b1;
              water_q <= 1'b0;
            end
          end else if (!req_none) begin
            state   <= FAULT;
            fault_q <= 1'b1;
          end
        end

        FILL, SOAK, WASH, RINSE, DRAIN, SPIN: begin
          if (!active_req) begin
            state   <= IDLE;
            cnt     <= '0;
            fill_q  <= 1'b0;
            drain_q <= 1'b0;
            motor_q <= 1'b0;
            fast_q  <= 1'b0;
            lock_q  <= 1'b0;
          end else if (bus.lid || (needs_water && !water_q)) begin
            state <= state;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (state == RINSE) begin
            state   <= DRAIN;
            cnt     <= DRAIN_LOAD;
            motor_q <= 1'b0;
            drain_q <= 1'b1;
            water_q <= 1'b0;
          end else begin
            state   <= DONE;
            done_q  <= phase_bit;
            fill_q  <= 1'b0;
            drain_q <= 1'b0;
            motor_q <= 1'b0;
            fast_q  <= 1'b0;
            if (state == FILL) water_q <= 1'b1;
          end
        end

        DONE: begin
          if (req_none) begin
            state  <= IDLE;
            lock_q <= 1'b0;
          end
        end

        FAULT: begin
          if (req_none) begin
            state   <= IDLE;
            fault_q <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Opening the lid stops the motor and inlet immediately; drain keeps running.
  assign bus.fill_valve  = fill_q  & ~bus.lid;
  assign bus.motor_en    = motor_q & ~bus.lid;
  assign bus.motor_fast  = fast_q  & ~bus.lid;
  assign bus.drain_valve = drain_q;
  assign bus.lid_lock    = lock_q;
  assign bus.fault       = fault_q;
  assign bus.water_full  = water_q;
  assign bus.fill_done   = done_q[0];
  assign bus.soak_done   = done_q[1];
  assign bus.wash_done   = done_q[2];
  assign bus.rinse_done  = done_q[3];
  assign bus.spin_done   = done_q[4];
  assign state_dbg       = state;

`ifdef WM_RESP_STATUS_EN
  assign phase_remaining = cnt;

  always_comb begin
    phase_code = 3'd7;
    case (state)
      IDLE:    phase_code = 3'd0;
      FILL:    phase_code = 3'd1;
      SOAK:    phase_code = 3'd2;
      WASH:    phase_code = 3'd3;
      RINSE:   phase_code = 3'd4;
      DRAIN:   phase_code = 3'd5;
      SPIN:    phase_code = 3'd6;
      default: phase_code = 3'd7;
    endcase
  end
`endif

endmodule

// File: tb/tb_wm_cycle_responder.sv
// Bench for wm_cycle_responder: directed scenarios then random request/lid/reset traffic,
// every cycle compared against a progress-counting behavioural model.
module tb_wm_cycle_responder;
  localparam int FILL_N  = 4;
  localparam int SOAK_N  = 5;
  localparam int WASH_N  = 8;
  localparam int RINSE_N = 4;
  localparam int DRAIN_N = 2;
  localparam int SPIN_N  = 6;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] state_dbg;
`ifdef WM_RESP_STATUS_EN
  logic [15:0] phase_remaining;
  logic [2:0]  phase_code;
`endif

  wm_cycle_responder_if bus();

  wm_cycle_responder #(
    .CNT_W(16), .FILL_CYCLES(FILL_N), .SOAK_CYCLES(SOAK_N), .WASH_CYCLES(WASH_N),
    .RINSE_CYCLES(RINSE_N), .DRAIN_CYCLES(DRAIN_N), .SPIN_CYCLES(SPIN_N)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus),
    .state_dbg(state_dbg)
`ifdef WM_RESP_STATUS_EN
    ,
    .phase_remaining(phase_remaining),
    .phase_code(phase_code)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: a running phase is described by the op and how many active cycles it has had
  typedef enum {M_IDLE, M_RUN, M_HOLD, M_FAULT} mode_t;
  mode_t      m_mode  = M_IDLE;
  int         m_op    = 0;
  int         m_prog  = 0;
  bit         m_water = 1'b0;
  logic [4:0] m_pulse = 5'd0;

  function automatic int op_len(input int op);
    case (op)
      0:       return FILL_N;
      1:       return SOAK_N;
      2:       return WASH_N;
      3:       return RINSE_N + DRAIN_N;
      default: return SPIN_N;
    endcase
  endfunction

  function automatic logic [4:0] onehot(input int op);
    logic [4:0] v;
    v = 5'd1 << op;
    return v;
  endfunction

  task automatic model_edge(input logic [4:0] r, input logic l);
    bit dry;
    m_pulse = 5'd0;
    case (m_mode)
      M_IDLE: begin
        if ($countones(r) == 1) begin
          for (int i = 0; i < 5; i++) if (r[i]) m_op = i;
          if (m_op == 0 && m_water) begin
            m_mode     = M_HOLD;
            m_pulse[0] = 1'b1;
          end else begin
            m_mode = M_RUN;
            m_prog = 0;
            if (m_op == 4) m_water = 1'b0;
          end
        end else if (r != 5'd0) begin
          m_mode = M_FAULT;
        end
      end
      M_RUN: begin
        dry = !m_water && (m_op == 1 || m_op == 2 || (m_op == 3 && m_prog < RINSE_N));
        if (!r[m_op]) begin
          m_mode = M_IDLE;
        end else if (!l && !dry) begin
          m_prog++;
          if (m_prog == op_len(m_op)) begin
            m_mode        = M_HOLD;
            m_pulse[m_op] = 1'b1;
            if (m_op == 0) m_water = 1'b1;
          end else if (m_op == 3 && m_prog == RINSE_N) begin
            m_water = 1'b0;
          end
        end
      end
      default: if (r == 5'd0) m_mode = M_IDLE;
    endcase
  endtask

  function automatic logic [11:0] model_outs(input logic l);
    logic run, drn, fill, drain, motor, fast, lock, flt;
    run   = (m_mode == M_RUN);
    drn   = run && m_op == 3 && m_prog >= RINSE_N;
    fill  = run && m_op == 0 && !l;
    motor = run && !l && (m_op == 4 || (m_water && (m_op == 2 || (m_op == 3 && !drn))));
    fast  = run && !l && m_op == 4;
    drain = run && (m_op == 4 || drn);
    lock  = run || (m_mode == M_HOLD);
    flt   = (m_mode == M_FAULT);
    return {m_pulse, m_water, fill, drain, motor, fast, lock, flt};
  endfunction

  function automatic logic [4:0] dut_done();
    return {bus.spin_done, bus.rinse_done, bus.wash_done, bus.soak_done, bus.fill_done};
  endfunction

  function automatic logic [6:0] dut_act();
    return {bus.water_full, bus.fill_valve, bus.drain_valve, bus.motor_en, bus.motor_fast,
            bus.lid_lock, bus.fault};
  endfunction

  // driver: apply inputs, let one edge pass, compare on the falling edge
  task automatic cycle(input logic [4:0] r, input logic l);
    logic [11:0] e;
    {bus.spin_req, bus.rinse_req, bus.wash_req, bus.soak_req, bus.water_intake} = r;
    bus.lid = l;
    @(posedge clock);
    model_edge(r, l);
    exp_q.push_back(model_outs(l));
    @(negedge clock);
    e = exp_q.pop_front();
    check("done", 32'(dut_done()), 32'(e[11:7]));
    check("act", 32'(dut_act()), 32'(e[6:0]));
`ifdef WM_RESP_STATUS_EN
    begin
      int rem, code;
      logic drn;
      drn  = (m_mode == M_RUN) && m_op == 3 && m_prog >= RINSE_N;
      rem  = 0;
      code = (m_mode == M_IDLE) ? 0 : 7;
      if (m_mode == M_RUN) begin
        rem  = (m_op == 3 && !drn) ? RINSE_N - 1 - m_prog : op_len(m_op) - 1 - m_prog;
        code = drn ? 5 : m_op + 1;
      end
      check("remaining", 32'(phase_remaining), 32'(rem));
      check("code", 32'(phase_code), 32'(code));
    end
`endif
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_done", 32'(dut_done()), 32'd0);
    check("rst_act", 32'(dut_act()), 32'd0);
`ifdef WM_RESP_STATUS_EN
    check("rst_remaining", 32'(phase_remaining), 32'd0);
`endif
    m_mode  = M_IDLE;
    m_prog  = 0;
    m_water = 1'b0;
    m_pulse = 5'd0;
    exp_q.delete();
    #1 reset_n = 1'b1;
  endtask

  initial begin
    bus.lid = 1'b0;
    {bus.spin_req, bus.rinse_req, bus.wash_req, bus.soak_req, bus.water_intake} = 5'd0;
    #1;
    do_reset();

    // fill from empty, then wash with the lid open for three cycles and the request held long
    repeat (7) cycle(5'b00001, 1'b0);
    repeat (2) cycle(5'b00000, 1'b0);
    for (int k = 0; k < 14; k++) cycle(5'b00100, (k >= 3 && k <= 5));
    repeat (2) cycle(5'b00000, 1'b0);
    // rinse including drain
    repeat (9) cycle(5'b01000, 1'b0);
    repeat (2) cycle(5'b00000, 1'b0);
    // fill again, reset in the middle of a wash
    repeat (6) cycle(5'b00001, 1'b0);
    repeat (2) cycle(5'b00000, 1'b0);
    repeat (4) cycle(5'b00100, 1'b0);
    do_reset();
    repeat (2) cycle(5'b00000, 1'b0);
    // two requests together
    repeat (3) cycle(5'b10100, 1'b0);
    repeat (2) cycle(5'b00000, 1'b0);
    // spin cancelled at cycle 3
    for (int k = 0; k < 6; k++) cycle((k < 3) ? 5'b10000 : 5'b00000, 1'b0);
    // fill with the drum already full answers at once
    repeat (5) cycle(5'b00001, 1'b0);
    cycle(5'b00000, 1'b0);
    repeat (3) cycle(5'b00001, 1'b0);
    cycle(5'b00000, 1'b0);

    for (int t = 0; t < 150; t++) begin
      int kind, op, op2, hold;
      kind = int'($urandom_range(0, 11));
      op   = int'($urandom_range(0, 4));
      if (!m_water && $urandom_range(0, 1) == 1) op = 0;
      if (kind == 0) begin
        op2 = (op + int'($urandom_range(1, 4))) % 5;
        repeat ($urandom_range(1, 3)) cycle(onehot(op) | onehot(op2), $urandom_range(0, 3) == 0);
      end else begin
        hold = int'($urandom_range(1, op_len(op) + 6));
        for (int k = 0; k < hold; k++) begin
          cycle(onehot(op), $urandom_range(0, 7) == 0);
          if (kind == 1 && k == hold / 2) do_reset();
        end
      end
      repeat ($urandom_range(1, 3)) cycle(5'b00000, $urandom_range(0, 5) == 0);
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
